// File: rtl/test_seq_pkg.sv
// Shared definitions for the test sequencer: FSM states, per-channel result codes
// and default sizing.
package test_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_NEXT   = 3'd3,
      ST_REPORT = 3'd4
   } seq_state_t;

   localparam logic [1:0] RES_NONE    = 2'd0;
   localparam logic [1:0] RES_PASS    = 2'd1;
   localparam logic [1:0] RES_FAIL    = 2'd2;
   localparam logic [1:0] RES_TIMEOUT = 2'd3;

   localparam int DEF_NUM_TESTS      = 11;
   localparam int DEF_TIMEOUT_CYCLES = 1000;
   localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/test_channel_monitor.sv
// Per-channel watcher: detects the done rising edge and latches a single result
// code per campaign (first event wins, a same-cycle done edge beats a timeout).
module test_channel_monitor
   import test_seq_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_armed,
   input  logic i_force_timeout,
   input  logic i_test_done,
   input  logic i_test_passed,
   output logic o_captured,
   output logic o_pass,
   output logic o_fail,
   output logic o_timeout
);

   logic       r_done_q;
   logic [1:0] r_code;
   logic       w_event;

   assign w_event = i_test_done & ~r_done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done_q <= 1'b0;
         r_code   <= RES_NONE;
      end else begin
         r_done_q <= i_test_done;
         if (i_clear) begin
            r_code <= RES_NONE;
         end else if (r_code == RES_NONE) begin
            if (i_armed && w_event)
               r_code <= i_test_passed ? RES_PASS : RES_FAIL;
            else if (i_force_timeout)
               r_code <= RES_TIMEOUT;
         end
      end
   end

   assign o_captured = (r_code == RES_PASS) || (r_code == RES_FAIL);
   assign o_pass     = (r_code == RES_PASS);
   assign o_fail     = (r_code == RES_FAIL) || (r_code == RES_TIMEOUT);
   assign o_timeout  = (r_code == RES_TIMEOUT);

endmodule

// File: rtl/test_sequencer.sv
// Campaign controller: launches enabled test channels in parallel or one at a time,
// enforces a cycle timeout and reports per-channel results plus a global verdict.
module test_sequencer
   import test_seq_pkg::*;
#(
   parameter int NUM_TESTS      = DEF_NUM_TESTS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = DEF_CNT_W
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 seq_mode,
   input  logic [NUM_TESTS-1:0] enable_mask,
   output logic [NUM_TESTS-1:0] test_start,
   input  logic [NUM_TESTS-1:0] test_done,
   input  logic [NUM_TESTS-1:0] test_passed,
   output logic                 busy,
   output logic                 done,
   output logic                 all_passed,
   output logic [NUM_TESTS-1:0] pass_vec,
   output logic [NUM_TESTS-1:0] fail_vec,
   output logic [NUM_TESTS-1:0] timeout_vec,
   output logic [CNT_W-1:0]     cycle_count
);

   localparam logic [NUM_TESTS-1:0] ONE     = NUM_TESTS'(1);
   localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   seq_state_t           r_state, w_state_next;
   logic                 r_seq_mode;
   logic [NUM_TESTS-1:0] r_mask, r_active;
   logic [CNT_W-1:0]     r_tmo_cnt, r_cycle_cnt;

   logic [NUM_TESTS-1:0] w_captured, w_armed, w_force, w_run_set;
   logic [NUM_TESTS-1:0] w_remaining, w_next_ch, w_first_ch;
   logic                 w_clear, w_tmo_hit, w_all_done, w_accept;

   assign w_accept    = (r_state == ST_IDLE) && start;
   assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
   assign w_run_set   = r_seq_mode ? r_active : r_mask;
   assign w_all_done  = ((w_captured & w_run_set) == w_run_set);
   // Enabled channels strictly above the active one, and the lowest of those.
   assign w_remaining = r_mask & ~(r_active | (r_active - ONE));
   assign w_next_ch   = w_remaining & (~w_remaining + ONE);
   assign w_first_ch  = enable_mask & (~enable_mask + ONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_clear      = 1'b0;
      w_armed      = '0;
      w_force      = '0;
      test_start   = '0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_clear      = 1'b1;
               w_state_next = (enable_mask == '0) ? ST_REPORT : ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            busy         = 1'b1;
            test_start   = w_run_set;
            w_state_next = ST_WAIT;
         end
         ST_WAIT: begin
            busy       = 1'b1;
            test_start = w_run_set;
            w_armed    = w_run_set;
            if (w_all_done || w_tmo_hit) begin
               w_force      = w_tmo_hit ? w_run_set : '0;
               w_state_next = (r_seq_mode && (w_remaining != '0)) ? ST_NEXT : ST_REPORT;
            end
         end
         ST_NEXT: begin
            busy         = 1'b1;
            w_state_next = ST_LAUNCH;
         end
         ST_REPORT: begin
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_seq_mode  <= 1'b0;
         r_mask      <= '0;
         r_active    <= '0;
         r_tmo_cnt   <= '0;
         r_cycle_cnt <= '0;
      end else begin
         if (w_accept) begin
            r_seq_mode  <= seq_mode;
            r_mask      <= enable_mask;
            r_active    <= w_first_ch;
            r_cycle_cnt <= '0;
         end else if ((busy) && (r_cycle_cnt != '1)) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
         end
         if (r_state == ST_LAUNCH)    r_tmo_cnt <= '0;
         else if (r_state == ST_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
         if (r_state == ST_NEXT)      r_active  <= w_next_ch;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_TESTS; gi++) begin : g_mon
         test_channel_monitor u_mon (
            .clk             (clk),
            .reset_n         (reset_n),
            .i_clear         (w_clear),
            .i_armed         (w_armed[gi]),
            .i_force_timeout (w_force[gi]),
            .i_test_done     (test_done[gi]),
            .i_test_passed   (test_passed[gi]),
            .o_captured      (w_captured[gi]),
            .o_pass          (pass_vec[gi]),
            .o_fail          (fail_vec[gi]),
            .o_timeout       (timeout_vec[gi])
         );
      end
   endgenerate

   // Verdict is only meaningful once results are final.
   assign all_passed = ((r_state == ST_IDLE) || (r_state == ST_REPORT)) && (r_mask != '0)
                       && (fail_vec == '0) && ((pass_vec & r_mask) == r_mask);
   assign cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_test_sequencer.sv
// Randomised campaigns against a timing model of the sequencer: channel behaviours are
// drawn at random, expected launch windows and results are computed from the rules.
`timescale 1ns/1ps
module tb_test_sequencer;

   localparam int N     = 4;
   localparam int T     = 16;
   localparam int CW    = 16;
   localparam int NEVER = 100000;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk;
   logic          reset_n;
   logic          start, seq_mode;
   logic [N-1:0]  enable_mask, test_start, test_done, test_passed;
   logic          busy, done, all_passed;
   logic [N-1:0]  pass_vec, fail_vec, timeout_vec;
   logic [CW-1:0] cycle_count;

   logic          s_start, s_mode;
   logic [N-1:0]  s_mask, s_test_done, s_test_passed, s_test_start;
   logic          s_busy, s_done, s_all_passed;
   logic [N-1:0]  s_pass_vec, s_fail_vec, s_timeout_vec;
   logic [2:0]    s_cycle_count;

   int n_vec = 0;
   int n_err = 0;

   int ch_d[N];
   bit ch_pass[N];
   bit ch_stuck[N];
   bit ch_double[N];

   test_sequencer #(.NUM_TESTS(N), .TIMEOUT_CYCLES(T), .CNT_W(CW)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .seq_mode(seq_mode),
      .enable_mask(enable_mask), .test_start(test_start), .test_done(test_done),
      .test_passed(test_passed), .busy(busy), .done(done), .all_passed(all_passed),
      .pass_vec(pass_vec), .fail_vec(fail_vec), .timeout_vec(timeout_vec),
      .cycle_count(cycle_count)
   );

   test_sequencer #(.NUM_TESTS(N), .TIMEOUT_CYCLES(6), .CNT_W(3)) u_dut_sat (
      .clk(clk), .reset_n(reset_n), .start(s_start), .seq_mode(s_mode),
      .enable_mask(s_mask), .test_start(s_test_start), .test_done(s_test_done),
      .test_passed(s_test_passed), .busy(s_busy), .done(s_done), .all_passed(s_all_passed),
      .pass_vec(s_pass_vec), .fail_vec(s_fail_vec), .timeout_vec(s_timeout_vec),
      .cycle_count(s_cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int i, input int d, input bit p, input bit stuck, input bit dbl);
      ch_d[i] = d; ch_pass[i] = p; ch_stuck[i] = stuck; ch_double[i] = dbl;
   endtask

   // One campaign: interval 0 carries the accepted start; channels react to test_start.
   task automatic run_campaign(input string name, input bit mode, input logic [N-1:0] mask);
      int lo[N], hi[N], launch_at[N];
      bit cap[N], started[N];
      int r_int, l, e, e_max, ign, k, exp_cc;
      logic [N-1:0] x_pass, x_fail, x_tmo, exp_ts, ts_obs;
      bit x_all, exp_busy;
      x_pass = '0; x_fail = '0; x_tmo = '0;
      for (int i = 0; i < N; i++) begin
         cap[i] = mask[i] && !ch_stuck[i] && ch_d[i] >= 1 && ch_d[i] <= T;
         lo[i] = 0; hi[i] = -1; started[i] = 0; launch_at[i] = 0;
         if (mask[i]) begin
            x_pass[i] = cap[i] && ch_pass[i];
            x_fail[i] = !(cap[i] && ch_pass[i]);
            x_tmo[i]  = !cap[i];
         end
      end
      if (mask == '0) begin
         r_int = 1;
      end else if (!mode) begin
         e_max = 1;
         for (int i = 0; i < N; i++)
            if (mask[i]) begin
               e = 1 + (cap[i] ? ((ch_d[i] + 1 < T) ? ch_d[i] + 1 : T) : T);
               if (e > e_max) e_max = e;
            end
         for (int i = 0; i < N; i++)
            if (mask[i]) begin lo[i] = 1; hi[i] = e_max; end
         r_int = e_max + 1;
      end else begin
         l = 1; e = 0;
         for (int i = 0; i < N; i++)
            if (mask[i]) begin
               lo[i] = l;
               e = l + (cap[i] ? ((ch_d[i] + 1 < T) ? ch_d[i] + 1 : T) : T);
               hi[i] = e;
               l = e + 2;
            end
         r_int = e + 1;
      end
      x_all  = (mask != '0) && (x_fail == '0) && ((x_pass & mask) == mask);
      exp_cc = (r_int - 1 > CMAX) ? CMAX : r_int - 1;
      ign    = $urandom_range(0, r_int);

      for (int n = 0; n <= r_int + 1; n++) begin
         @(posedge clk); #1;
         exp_ts = '0;
         for (int i = 0; i < N; i++)
            if (n >= lo[i] && n <= hi[i]) exp_ts[i] = 1'b1;
         exp_busy = (mask != '0) && n >= 1 && n < r_int;
         check($sformatf("%s ts@%0d", name, n), test_start, exp_ts);
         check($sformatf("%s busy@%0d", name, n), busy, exp_busy);
         check($sformatf("%s done@%0d", name, n), done, (n == r_int));
         if (n >= r_int) begin
            check($sformatf("%s pass@%0d", name, n), pass_vec, x_pass);
            check($sformatf("%s fail@%0d", name, n), fail_vec, x_fail);
            check($sformatf("%s tmo@%0d", name, n), timeout_vec, x_tmo);
            check($sformatf("%s allp@%0d", name, n), all_passed, x_all);
            check($sformatf("%s ccnt@%0d", name, n), cycle_count, exp_cc);
         end
         $display("%s n=%0d ts=%b busy=%b done=%b pass=%b fail=%b tmo=%b", name, n,
                  test_start, busy, done, pass_vec, fail_vec, timeout_vec);
         ts_obs = test_start;
         start  = (n == 0) || (n == ign);
         if (n == 0) begin
            seq_mode = mode; enable_mask = mask;
         end else begin
            seq_mode = 1'($urandom_range(0, 1)); enable_mask = 4'($urandom_range(0, 15));
         end
         for (int i = 0; i < N; i++) begin
            if (ch_stuck[i]) begin
               test_done[i]   = 1'b1;
               test_passed[i] = 1'($urandom_range(0, 1));
            end else if (ts_obs[i]) begin
               if (!started[i]) begin started[i] = 1; launch_at[i] = n; end
               k = n - launch_at[i];
               if (k < ch_d[i]) test_done[i] = 1'b0;
               else if (ch_double[i]) test_done[i] = (k == ch_d[i]) || (k >= ch_d[i] + 2);
               else test_done[i] = 1'b1;
               test_passed[i] = (ch_double[i] && k >= ch_d[i] + 2) ? !ch_pass[i] : ch_pass[i];
            end else begin
               test_done[i]   = 1'($urandom_range(0, 1));
               test_passed[i] = 1'($urandom_range(0, 1));
            end
         end
      end
      start = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; start = 0; seq_mode = 0; enable_mask = '0;
      test_done = '0; test_passed = '0;
      s_start = 0; s_mode = 0; s_mask = '0; s_test_done = '0; s_test_passed = '0;
      #1;
      check("reset ts", test_start, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset results", {pass_vec, fail_vec, timeout_vec}, 0);
      check("reset allp", all_passed, 0);
      check("reset ccnt", cycle_count, 0);
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      for (int i = 0; i < N; i++) set_ch(i, 2 * i + 2, 1, 0, 0);
      run_campaign("par_allpass", 0, 4'b1111);

      set_ch(0, 3, 1, 0, 0); set_ch(1, 3, 0, 0, 0); set_ch(2, 5, 1, 0, 0); set_ch(3, NEVER, 1, 0, 0);
      run_campaign("par_fail_tmo", 0, 4'b1111);

      set_ch(0, 3, 1, 0, 0); set_ch(1, 2, 1, 0, 0); set_ch(2, 4, 1, 0, 0); set_ch(3, 2, 1, 0, 0);
      run_campaign("seq_0101", 1, 4'b0101);

      set_ch(0, 2, 1, 0, 0); set_ch(2, 3, 1, 1, 0);
      run_campaign("stuck_done", 0, 4'b0101);

      set_ch(0, T, 1, 0, 0); set_ch(1, NEVER, 1, 0, 0);
      run_campaign("done_at_tmo", 0, 4'b0011);

      set_ch(0, 2, 1, 0, 1); set_ch(1, 8, 1, 0, 0); set_ch(2, 2, 1, 0, 0);
      run_campaign("double_edge", 0, 4'b0011);

      run_campaign("mask_zero", 0, 4'b0000);

      // Reset in the middle of a parallel wait.
      for (int i = 0; i < N; i++) set_ch(i, NEVER, 1, 0, 0);
      @(posedge clk); #1; start = 1; seq_mode = 0; enable_mask = 4'b1111; test_done = '0;
      @(posedge clk); #1; start = 0;
      @(posedge clk); #1;
      @(posedge clk); #1; test_done = 4'b0001; test_passed = 4'b0001;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst pre pass", pass_vec, 4'b0001);
      check("rst pre busy", busy, 1);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("rst ts", test_start, 0);
      check("rst busy", busy, 0);
      check("rst results", {pass_vec, fail_vec, timeout_vec}, 0);
      check("rst ccnt", cycle_count, 0);
      $display("reset mid-wait ts=%b busy=%b pass=%b", test_start, busy, pass_vec);
      repeat (2) @(posedge clk);
      #1 test_done = '0; reset_n = 1'b1;

      for (int i = 0; i < N; i++) set_ch(i, i + 3, 1, 0, 0);
      run_campaign("post_reset", 0, 4'b1111);

      for (int c = 0; c < 40; c++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 9))
               0:       set_ch(i, NEVER, 1'($urandom_range(0, 1)), 1, 0);
               1:       set_ch(i, NEVER, 1'($urandom_range(0, 1)), 0, 0);
               default: set_ch(i, $urandom_range(1, T + 2), 1'($urandom_range(0, 1)), 0,
                               ($urandom_range(0, 3) == 0));
            endcase
         end
         run_campaign($sformatf("rnd%0d", c), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end

      // Narrow counter: two sequential timeouts of 6 cycles overrun a 3-bit count.
      @(posedge clk); #1; s_start = 1; s_mode = 1; s_mask = 4'b0011;
      @(posedge clk); #1; s_start = 0;
      for (int k = 0; k < 100 && !s_done; k++) begin
         @(posedge clk); #1;
      end
      check("sat done", s_done, 1);
      check("sat ccnt", s_cycle_count, 3'd7);
      check("sat tmo", s_timeout_vec, 4'b0011);
      check("sat fail", s_fail_vec, 4'b0011);
      $display("saturation done=%b ccnt=%0d tmo=%b", s_done, s_cycle_count, s_timeout_vec);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
